// File: rtl/uart_frame_ctrl.sv
// Parses SOF/LEN/payload/CHK frames from the UART byte stream into an external payload buffer.
// Writes land 1 cycle after each byte; a held frame is released by frame_ack, rx bytes arriving meanwhile are overruns.
module uart_frame_ctrl #(
    parameter int         MAX_LEN     = 64,
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 50_000,
    parameter int         ADDR_W      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_framing_err,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_frame_valid,
    output logic [7:0]        o_frame_len,
    input  logic              i_frame_ack,
    output logic              o_frame_err,
    output logic [2:0]        o_err_code,
    output logic              o_busy
);

    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYC);
    localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CHK     = 3'd2;
    localparam logic [2:0] ERR_FRAMING = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_len, w_len_nxt;
    logic [7:0]        r_chk, w_chk_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]        r_wr_data, w_wr_data_nxt;
    logic              r_frame_valid, w_frame_valid_nxt;
    logic [7:0]        r_frame_len, w_frame_len_nxt;
    logic              r_frame_err, w_frame_err_nxt;
    logic [2:0]        r_err_code, w_err_code_nxt;
    logic              r_busy;

    logic w_active, w_expire, w_is_sof, w_len_ok, w_bad_fe;

    assign w_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // A byte on the expiring cycle keeps the frame alive.
    assign w_expire = w_active && !i_rx_valid && (r_to_cnt == TO_LAST);
    assign w_is_sof = i_rx_valid && !i_rx_framing_err && (i_rx_data == SOF_BYTE);
    assign w_len_ok = (i_rx_data != 8'd0) && (i_rx_data <= LEN_MAX);
    assign w_bad_fe = i_rx_valid && i_rx_framing_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len         <= 8'd0;
            r_chk         <= 8'd0;
            r_cnt         <= 8'd0;
            r_to_cnt      <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= 8'd0;
            r_frame_valid <= 1'b0;
            r_frame_len   <= 8'd0;
            r_frame_err   <= 1'b0;
            r_err_code    <= 3'd0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_chk         <= w_chk_nxt;
            r_cnt         <= w_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_addr     <= w_wr_addr_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_err_code    <= w_err_code_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_is_sof) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (i_rx_valid) w_state_nxt = (!i_rx_framing_err && w_len_ok) ? S_PAYLOAD : S_IDLE;
                else if (w_expire) w_state_nxt = S_IDLE;
            end
            S_PAYLOAD: begin
                if (w_bad_fe) w_state_nxt = S_IDLE;
                else if (i_rx_valid && (r_cnt == r_len - 8'd1)) w_state_nxt = S_CHK;
                else if (w_expire) w_state_nxt = S_IDLE;
            end
            S_CHK: begin
                if (i_rx_valid) w_state_nxt = (!i_rx_framing_err && (i_rx_data == r_chk)) ? S_HOLD : S_IDLE;
                else if (w_expire) w_state_nxt = S_IDLE;
            end
            S_HOLD: begin
                // An ack frees the buffer in the same cycle, so a coinciding byte is treated as if idle.
                if (i_frame_ack) w_state_nxt = w_is_sof ? S_LEN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_len_nxt         = r_len;
        w_chk_nxt         = r_chk;
        w_cnt_nxt         = r_cnt;
        w_wr_en_nxt       = 1'b0;
        w_wr_addr_nxt     = r_wr_addr;
        w_wr_data_nxt     = r_wr_data;
        w_frame_valid_nxt = r_frame_valid;
        w_frame_len_nxt   = r_frame_len;
        w_frame_err_nxt   = 1'b0;
        w_err_code_nxt    = r_err_code;

        if (!w_active || i_rx_valid) w_to_cnt_nxt = '0;
        else if (r_to_cnt == TO_SAT) w_to_cnt_nxt = r_to_cnt;
        else                         w_to_cnt_nxt = r_to_cnt + 1'b1;

        if (w_bad_fe && w_active) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_FRAMING;
        end else if (w_expire) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_TIMEOUT;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (i_rx_valid && w_len_ok) begin
                        w_len_nxt = i_rx_data;
                        w_chk_nxt = i_rx_data;
                        w_cnt_nxt = 8'd0;
                    end else if (i_rx_valid) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_LEN;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_valid) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_cnt[ADDR_W-1:0];
                        w_wr_data_nxt = i_rx_data;
                        w_chk_nxt     = r_chk ^ i_rx_data;
                        w_cnt_nxt     = r_cnt + 8'd1;
                    end
                end
                S_CHK: begin
                    if (i_rx_valid && (i_rx_data == r_chk)) begin
                        w_frame_valid_nxt = 1'b1;
                        w_frame_len_nxt   = r_len;
                    end else if (i_rx_valid) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_CHK;
                    end
                end
                S_HOLD: begin
                    if (i_frame_ack) begin
                        w_frame_valid_nxt = 1'b0;
                    end else if (i_rx_valid) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_OVERRUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_len   = r_frame_len;
    assign o_frame_err   = r_frame_err;
    assign o_err_code    = r_err_code;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed scenarios plus randomized frames scored against a frame-level model.
module tb_uart_frame_ctrl;
    localparam int MAX_LEN = 64;
    localparam int TO      = 60;
    localparam int AW      = $clog2(MAX_LEN);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_fe, frame_ack;
    logic          wr_en, frame_valid, frame_err, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data, frame_len;
    logic [2:0]    err_code;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    logic [2:0]    ec_q[$];
    bit            fv_seen;
    logic [7:0]    pl[256];

    uart_frame_ctrl #(.MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_framing_err(rx_fe),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_frame_valid(frame_valid), .o_frame_len(frame_len), .i_frame_ack(frame_ack),
        .o_frame_err(frame_err), .o_err_code(err_code), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end
            if (frame_err) ec_q.push_back(err_code);
            if (frame_valid) fv_seen = 1'b1;
        end
    end

    task automatic clear_obs();
        @(negedge clk);
        wa_q.delete(); wd_q.delete(); ec_q.delete(); fv_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; rx_fe = fe;
        @(negedge clk);
        rx_valid = 1'b0; rx_fe = 1'b0;
    endtask

    // Fills pl with random payload and sends a frame; fe_pos >= 0 cuts it with a framing error at that payload index.
    task automatic drive_frame(input int len, input bit bad_chk, input int fe_pos);
        logic [7:0] chk;
        chk = 8'(len);
        for (int i = 0; i < len; i++) begin
            pl[i] = 8'($urandom);
            chk ^= pl[i];
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'(len), 1'b0);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == fe_pos) begin
                send_byte(pl[i], 1'b1);
                return;
            end
            send_byte(pl[i], 1'b0);
        end
        if (bad_chk) chk ^= 8'($urandom_range(1, 255));
        send_byte(chk, 1'b0);
    endtask

    task automatic pulse_ack();
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_fe = 1'b0; rx_data = 8'h00; frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (wr_en !== 1'b0)       begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== '0)       begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== 8'h00)    begin bad++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
        total++; if (frame_len !== 8'h00)  begin bad++; $display("FAIL reset_frame_len got=%h exp=00", frame_len); end
        total++; if (frame_err !== 1'b0)   begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (err_code !== 3'd0)    begin bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        clear_obs();
        send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(exp_d[i], 1'b0);
        send_byte(8'h03, 1'b0);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b exp=1", frame_valid); end
        total++; if (frame_len !== 8'd3)   begin bad++; $display("FAIL good_len got=%0d exp=3", frame_len); end
        total++; if (wa_q.size() != 3)     begin bad++; $display("FAIL good_nwr got=%0d exp=3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_d[i]) begin
                bad++; $display("FAIL good_wr%0d got=%0d/%h exp=%0d/%h", i, wa_q[i], wd_q[i], i, exp_d[i]);
            end
        end
        repeat (6) @(negedge clk);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL good_held got=%b exp=1", frame_valid); end
        pulse_ack();
        total++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL good_release got=%b/%b exp=0/0", frame_valid, busy);
        end
        total++; if (ec_q.size() != 0) begin bad++; $display("FAIL good_noerr got=%0d errs exp=0", ec_q.size()); end
    endtask

    task automatic test_bad_chk();
        clear_obs();
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'h00, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (ec_q.size() != 1 || ec_q[0] !== 3'd2) begin
            bad++; $display("FAIL badchk_err got=%0d pulses exp=1 pulse code 2", ec_q.size());
        end
        total++; if (fv_seen !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL badchk_state got=fv%b/busy%b exp=0/0", fv_seen, busy);
        end
    endtask

    task automatic test_len_bounds();
        logic [7:0] bad_lens[2];
        bad_lens[0] = 8'd0; bad_lens[1] = 8'(MAX_LEN + 1);
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            send_byte(8'hA5, 1'b0); send_byte(bad_lens[k], 1'b0);
            @(negedge clk);
            total++; if (ec_q.size() != 1 || ec_q[0] !== 3'd1 || busy !== 1'b0) begin
                bad++; $display("FAIL len_%0d got=%0d pulses busy=%b exp=1 pulse code 1 busy=0", bad_lens[k], ec_q.size(), busy);
            end
        end
        clear_obs();
        drive_frame(MAX_LEN, 1'b0, -1);
        total++; if (frame_valid !== 1'b1 || frame_len !== 8'(MAX_LEN)) begin
            bad++; $display("FAIL maxlen_valid got=%b/%0d exp=1/%0d", frame_valid, frame_len, MAX_LEN);
        end
        total++; if (wa_q.size() != MAX_LEN) begin bad++; $display("FAIL maxlen_nwr got=%0d exp=%0d", wa_q.size(), MAX_LEN); end
        else begin
            total++; if (wa_q[MAX_LEN-1] !== AW'(MAX_LEN - 1) || wd_q[MAX_LEN-1] !== pl[MAX_LEN-1]) begin
                bad++; $display("FAIL maxlen_last got=%0d/%h exp=%0d/%h", wa_q[MAX_LEN-1], wd_q[MAX_LEN-1], MAX_LEN - 1, pl[MAX_LEN-1]);
            end
        end
        pulse_ack();
    endtask

    task automatic test_timeout();
        int fire_k;
        clear_obs();
        send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h01, 1'b0);
        fire_k = 0;
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge clk);
            if (frame_err === 1'b1 && fire_k == 0) fire_k = k;
        end
        total++; if (fire_k != TO) begin bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", fire_k, TO); end
        total++; if (ec_q.size() != 1 || ec_q[0] !== 3'd4 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_code got=%0d pulses busy=%b exp=1 pulse code 4 busy=0", ec_q.size(), busy);
        end
    endtask

    task automatic test_framing_err();
        clear_obs();
        drive_frame(5, 1'b0, 2);
        @(negedge clk);
        total++; if (ec_q.size() != 1 || ec_q[0] !== 3'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL framing_err got=%0d pulses busy=%b exp=1 pulse code 3 busy=0", ec_q.size(), busy);
        end
        total++; if (wa_q.size() != 2) begin bad++; $display("FAIL framing_nwr got=%0d exp=2", wa_q.size()); end
    endtask

    task automatic test_hold();
        clear_obs();
        drive_frame(4, 1'b0, -1);
        send_byte(8'h55, 1'b0);
        total++; if (ec_q.size() != 1 || ec_q[0] !== 3'd5) begin bad++; $display("FAIL overrun_err got=%0d pulses exp=1 pulse code 5", ec_q.size()); end
        total++; if (frame_valid !== 1'b1 || frame_len !== 8'd4) begin
            bad++; $display("FAIL overrun_held got=%b/%0d exp=1/4", frame_valid, frame_len);
        end
        @(negedge clk);
        frame_ack = 1'b1; rx_data = 8'hA5; rx_valid = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0; rx_valid = 1'b0;
        total++; if (frame_valid !== 1'b0 || busy !== 1'b1 || ec_q.size() != 1) begin
            bad++; $display("FAIL ack_sof got=fv%b busy%b errs%0d exp=fv0 busy1 errs1", frame_valid, busy, ec_q.size());
        end
        wa_q.delete(); wd_q.delete();
        send_byte(8'h02, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h32, 1'b0);
        total++; if (frame_valid !== 1'b1 || frame_len !== 8'd2 || wa_q.size() != 2) begin
            bad++; $display("FAIL ack_sof_frame got=%b/%0d/%0d exp=1/2/2", frame_valid, frame_len, wa_q.size());
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_err, err_code, busy} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%b%0d%h%b%h%b%0d%b exp=all zero", wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_err, err_code, busy);
        end
        rst = 1'b0;
        clear_obs();
        drive_frame(3, 1'b0, -1);
        total++; if (wa_q.size() != 3 || wa_q[0] !== '0 || wd_q[0] !== pl[0] || frame_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_next got=%0d writes fv=%b exp=3 writes from addr 0 fv=1", wa_q.size(), frame_valid);
        end
        total++; if (ec_q.size() != 0) begin bad++; $display("FAIL rstmid_noerr got=%0d exp=0", ec_q.size()); end
        pulse_ack();
    endtask

    task automatic test_random();
        int kind, len, fe_pos, exp_nwr;
        logic [7:0] jb;
        logic [2:0] exp_code;
        for (int n = 0; n < 25; n++) begin
            clear_obs();
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, ($urandom_range(0, 3) == 0));
            end
            kind = $urandom_range(0, 3);
            len = $urandom_range(1, MAX_LEN);
            fe_pos = -1; exp_code = 3'd0; exp_nwr = len;
            if (kind == 1) exp_code = 3'd2;
            if (kind == 2) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                exp_code = 3'd1; exp_nwr = 0;
                send_byte(8'hA5, 1'b0); send_byte(8'(len), 1'b0);
            end else begin
                if (kind == 3) begin
                    fe_pos = $urandom_range(0, len - 1);
                    exp_code = 3'd3; exp_nwr = fe_pos;
                end
                drive_frame(len, kind == 1, fe_pos);
            end
            @(negedge clk);
            total++; if (wa_q.size() != exp_nwr) begin bad++; $display("FAIL rnd%0d_nwr got=%0d exp=%0d", n, wa_q.size(), exp_nwr); end
            for (int i = 0; i < exp_nwr && i < wa_q.size(); i++) begin
                if (wa_q[i] !== AW'(i) || wd_q[i] !== pl[i]) begin
                    total++; bad++;
                    $display("FAIL rnd%0d_wr%0d got=%0d/%h exp=%0d/%h", n, i, wa_q[i], wd_q[i], i, pl[i]);
                end
            end
            if (exp_code == 3'd0) begin
                total++; if (frame_valid !== 1'b1 || frame_len !== 8'(len) || ec_q.size() != 0) begin
                    bad++; $display("FAIL rnd%0d_good got=%b/%0d/%0d errs exp=1/%0d/0", n, frame_valid, frame_len, ec_q.size(), len);
                end
                pulse_ack();
            end else begin
                total++; if (ec_q.size() != 1 || ec_q[0] !== exp_code || fv_seen || busy !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_err got=%0d pulses fv=%b busy=%b exp=1 pulse code %0d", n, ec_q.size(), fv_seen, busy, exp_code);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_bounds();
        test_timeout();
        test_framing_err();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
